phy_rx_aligner: RTL
===================

# phy_rx_aligner

Parametrised receive-side deserializer and symbol aligner for the PHY receive lane. It takes a one-bit-per-cycle serial stream and hunts for the comma symbol (COM) at any bit offset. It declares lock after a configurable number of consecutive aligned COMs, then delivers parallel data symbols with a valid strobe. Compared with the fixed 8-bit, lock-after-4-BC receiver, it adds a parametrised symbol width, comma and idle values, lock depth, and loss-of-lock detection.

## Interface
Parameters:
- WIDTH, 8, symbol width in bits (≥ 4).
- COM, 8'hBC, comma/alignment symbol (WIDTH bits).
- IDLE, 8'h7C, idle filler symbol (WIDTH bits).
- LOCK_COUNT, 4, consecutive aligned COMs required to lock (≥ 1).
- GAP_MAX, 16, symbols allowed without a COM before lock is dropped; 0 disables the drop.

Ports:
- clk_32f  input  1  bit-rate clock; the only clock, all logic rising-edge.
- reset  input  1  synchronous, active-high.
- data_in  input  1  serial bit, MSB of each symbol first.
- data_out  output  WIDTH  last received data symbol.
- valid_out  output  1  one-cycle strobe, data_out updated this cycle.
- active  output  1  high while in LOCKED.
- lock_err  output  1  one-cycle pulse when lock is dropped by a gap timeout.

## Operation
- Shift register: sr <= {sr[WIDTH-2:0], data_in} every cycle in all states. The candidate symbol nxt = {sr[WIDTH-2:0], data_in}.
- HUNT (reset state): compare nxt to COM every cycle.
  - On a match: bit counter cnt <= 0 (the next bit is the MSB of the next symbol) and com_cnt <= 1.
  - Then go to SYNC, or straight to LOCKED if LOCK_COUNT == 1.
- Symbol boundary in SYNC/LOCKED: cnt counts 0..WIDTH-1 and wraps. A symbol completes on the cycle where cnt == WIDTH-1, and nxt is evaluated then.
- SYNC, on each completed symbol:
  - nxt == COM: com_cnt++. When it reaches LOCK_COUNT, go to LOCKED.
  - otherwise: go to HUNT and set com_cnt <= 0. No re-check of that same cycle's nxt.
- LOCKED, on each completed symbol:
  - nxt == COM: gap counter gap <= 0; no valid.
  - nxt == IDLE: gap++; no valid.
  - any other value: data_out <= nxt, valid_out <= 1, gap++.
- Gap timeout: if GAP_MAX != 0 and gap would reach GAP_MAX, go to HUNT with active <= 0 and lock_err <= 1 for one cycle.
  - Timeout wins over a data symbol completing on the same cycle: no valid.
- Counter widths: cnt is $clog2(WIDTH); com_cnt is $clog2(LOCK_COUNT+1); gap is $clog2(GAP_MAX+1), saturating when GAP_MAX == 0.
- data_out holds its value between strobes, across lock loss, and across relock. Only reset clears it.

## Timing
- Reset values: data_out = 0, valid_out = 0, active = 0, lock_err = 0. Internal state: HUNT, with sr, cnt, com_cnt and gap all 0.
- Reset mid-symbol or mid-lock takes effect at the next clk_32f edge. A full LOCK_COUNT fresh COMs are needed to relock.
- All outputs are registered. Latency is 1 cycle: the symbol whose LSB is sampled at edge k appears on data_out/valid_out after edge k.
- active rises at the edge sampling the LSB of the LOCK_COUNT-th COM. The first possible valid_out comes WIDTH cycles later.
- valid_out is asserted at most once per WIDTH cycles and is never high in HUNT or SYNC.
- lock_err and the active fall occur on the same edge.
- In HUNT, a COM pattern is detected at any offset, including patterns straddling garbage bits. The earliest match wins.

## Test plan
- Reset, 3 garbage bits (1,0,1), 4×8'hBC, then 8'hA5:
  - active rises on the 32nd COM bit edge.
  - 8 cycles later: one valid_out pulse with data_out = 8'hA5.
- 3×8'hBC then 8'h11:
  - return to HUNT; active stays 0, no valid.
  - then 4×BC followed by 8'h3C: locks and outputs 8'h3C.
- Locked, then 16×8'h7C:
  - on the 16th IDLE LSB edge, active falls and lock_err pulses once.
  - no valid_out throughout.
- Locked, repeating pattern BC, 8 data bytes 8'h00..8'h07, BC, …, for 100 symbols:
  - active stays 1; valid_out fires for every data byte, in order.
  - no lock_err.
- Locked, reset asserted for 1 cycle mid-symbol:
  - next edge: all outputs are 0.
  - 3 COMs do not lock; the 4th does.
- WIDTH=10, COM=10'h17C, IDLE=10'h0FC, LOCK_COUNT=2, GAP_MAX=0:
  - 2 COMs lock; 10'h2AA is received as data.
  - 100 IDLEs cause no lock loss.

Source files
------------

// File: rtl/phy_rx_aligner.sv
// Receive-lane deserializer and symbol aligner: hunts for the comma symbol at
// any bit offset, locks after LOCK_COUNT aligned commas, then strobes out data
// symbols and drops lock if too many symbols pass without a comma.
module phy_rx_aligner #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM        = 8'hBC,
  parameter logic [WIDTH-1:0] IDLE       = 8'h7C,
  parameter int unsigned      LOCK_COUNT = 4,
  parameter int unsigned      GAP_MAX    = 16
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic             lock_err
);

  localparam int unsigned CW  = $clog2(WIDTH);
  localparam int unsigned LCW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned GW  = (GAP_MAX == 0) ? 1 : $clog2(GAP_MAX + 1);

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [LCW:0]  LOCK_LIM = (LCW + 1)'(LOCK_COUNT);
  localparam logic [GW:0]   GAP_LIM  = (GW + 1)'(GAP_MAX);

  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;

  state_t           state, state_nxt;
  // Only the newest WIDTH-1 bits are ever read, so the oldest bit of the
  // shift register is not kept.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] nxt;
  logic [CW-1:0]    cnt, cnt_d;
  logic [LCW-1:0]   com_cnt, com_cnt_d;
  logic [LCW:0]     com_inc;
  logic [GW-1:0]    gap, gap_d;
  logic [GW:0]      gap_inc;
  logic             is_com, is_idle, sym_done, timeout;
  logic [WIDTH-1:0] data_d;
  logic             valid_d, active_d, lock_err_d;

  assign nxt      = {sr, data_in};
  assign is_com   = (nxt == COM);
  assign is_idle  = (nxt == IDLE);
  assign sym_done = (cnt == LAST_BIT);
  assign com_inc  = {1'b0, com_cnt} + (LCW + 1)'(1);
  assign gap_inc  = {1'b0, gap} + (GW + 1)'(1);

  // State register plus registered datapath and outputs
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= HUNT;
      sr        <= '0;
      cnt       <= '0;
      com_cnt   <= '0;
      gap       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      lock_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= nxt[WIDTH-2:0];
      cnt       <= cnt_d;
      com_cnt   <= com_cnt_d;
      gap       <= gap_d;
      data_out  <= data_d;
      valid_out <= valid_d;
      active    <= active_d;
      lock_err  <= lock_err_d;
    end
  end

  // Next-state decode, including the gap timeout that forces a return to HUNT
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      HUNT: begin
        if (is_com) state_nxt = (LOCK_COUNT == 1) ? LOCKED : SYNC;
      end
      SYNC: begin
        if (sym_done) begin
          if (!is_com)                  state_nxt = HUNT;
          else if (com_inc == LOCK_LIM) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (sym_done && !is_com && (GAP_MAX != 0) && (gap_inc == GAP_LIM)) begin
          timeout   = 1'b1;
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Counter updates and next values of the registered outputs
  always_comb begin
    cnt_d      = sym_done ? '0 : cnt + CW'(1);
    com_cnt_d  = com_cnt;
    gap_d      = gap;
    data_d     = data_out;
    valid_d    = 1'b0;
    active_d   = (state_nxt == LOCKED);
    lock_err_d = timeout;
    case (state)
      HUNT: begin
        cnt_d = '0;
        if (is_com) begin
          com_cnt_d = LCW'(1);
          gap_d     = '0;
        end
      end
      SYNC: begin
        if (sym_done) begin
          if (is_com) begin
            com_cnt_d = com_inc[LCW-1:0];
            gap_d     = '0;
          end else begin
            com_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (sym_done) begin
          if (is_com) begin
            gap_d = '0;
          end else if (timeout) begin
            gap_d     = '0;
            com_cnt_d = '0;
          end else begin
            gap_d = (&gap) ? gap : gap_inc[GW-1:0];
            if (!is_idle) begin
              data_d  = nxt;
              valid_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule
